// File: rtl/lc2k_mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lc2k_mc_control                                              |
// | Description : Multi-cycle LC2K control FSM with memory-stall fault         |
// |               watchdog. Optional LC2K_CTRL_PERF_EN adds cycle/instr counts.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lc2k_mc_control #(
    parameter int OPCODE_W = 3,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                alu_eq,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic [1:0]          wb_src,
    output logic                alu_srcB,
    output logic [1:0]          alu_op,
    output logic                halted,
    output logic                fault,
    output logic [2:0]          state
`ifdef LC2K_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    instr_count
`endif
);

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_NOR  = 3'd1;
    localparam logic [2:0] c_OP_LW   = 3'd2;
    localparam logic [2:0] c_OP_SW   = 3'd3;
    localparam logic [2:0] c_OP_BEQ  = 3'd4;
    localparam logic [2:0] c_OP_JALR = 3'd5;
    localparam logic [2:0] c_OP_HALT = 3'd6;
    localparam logic [2:0] c_OP_NOOP = 3'd7;
    localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op_q;
    logic [2:0] w_op_dec;
    logic [7:0] r_wait_cnt;
    logic       w_wait_expired;

    // Opcodes wider than 3 bits with any upper bit set are treated as noop.
    generate
        if (OPCODE_W > 3) begin : g_op_wide
            assign w_op_dec = (|opcode[OPCODE_W-1:3]) ? c_OP_NOOP : opcode[2:0];
        end else begin : g_op_narrow
            assign w_op_dec = opcode[2:0];
        end
    endgenerate

    assign w_wait_expired = (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_op_q     <= c_OP_NOOP;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= w_op_dec;
            end
            if (mem_ready || (w_next != r_state)) begin
                r_wait_cnt <= 8'd0;
            end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        wb_src       = 2'd0;
        alu_srcB     = 1'b0;
        alu_op       = 2'd0;
        halted       = 1'b0;
        fault        = 1'b0;
        state        = r_state;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_wait_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                case (w_op_dec)
                    c_OP_HALT: w_next = S_HALT;
                    c_OP_NOOP: begin
                        pc_write = 1'b1;
                        w_next   = S_FETCH;
                    end
                    default:   w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (r_op_q)
                    c_OP_ADD: begin
                        alu_srcB = 1'b1;
                        w_next   = S_WB;
                    end
                    c_OP_NOR: begin
                        alu_srcB = 1'b1;
                        alu_op   = 2'd1;
                        w_next   = S_WB;
                    end
                    c_OP_LW, c_OP_SW: w_next = S_MEM;
                    c_OP_BEQ: begin
                        alu_srcB = 1'b1;
                        alu_op   = 2'd2;
                        pc_write = 1'b1;
                        pc_src   = alu_eq ? 2'd1 : 2'd0;
                    end
                    c_OP_JALR: begin
                        reg_write = 1'b1;
                        wb_src    = 2'd2;
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = (r_op_q == c_OP_SW);
                if (mem_ready) begin
                    if (r_op_q == c_OP_SW) begin
                        pc_write = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_wait_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (r_op_q != c_OP_LW) begin
                    reg_dst = 1'b1;
                    wb_src  = 2'd1;
                end
                w_next = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: w_next = S_FETCH;
        endcase

        // Reset aborts any in-flight access: nothing may be committed this cycle.
        if (reset) begin
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 2'd0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_src = 1'b0;
            reg_write    = 1'b0;
            reg_dst      = 1'b0;
            wb_src       = 2'd0;
            alu_srcB     = 1'b0;
            alu_op       = 2'd0;
            halted       = 1'b0;
            fault        = 1'b0;
            state        = S_FETCH;
        end
    end

`ifdef LC2K_CTRL_PERF_EN
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_instr_evt;

    assign w_instr_evt = pc_write || ((r_state == S_DECODE) && (w_next == S_HALT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if ((r_state != S_HALT) && (r_state != S_FAULT) && !(&r_cycle_count)) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
            if (w_instr_evt && !(&r_instr_count)) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc2k_mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lc2k_mc_control                                           |
// | Description : Directed self-checking bench for lc2k_mc_control.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lc2k_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic       mem_ready;
    logic       alu_eq;
    logic       ir_write, pc_write, mem_req, mem_we, mem_addr_src;
    logic       reg_write, reg_dst, alu_srcB, halted, fault;
    logic [1:0] pc_src, wb_src, alu_op;
    logic [2:0] state;
`ifdef LC2K_CTRL_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lc2k_mc_control #(.OPCODE_W(3), .MAX_WAIT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .alu_eq(alu_eq),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_src(mem_addr_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .wb_src(wb_src), .alu_srcB(alu_srcB), .alu_op(alu_op),
        .halted(halted), .fault(fault), .state(state)
`ifdef LC2K_CTRL_PERF_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    logic [18:0] obs;
    assign obs = {ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_src, reg_write,
                  reg_dst, wb_src, alu_srcB, alu_op, halted, fault, state};

    function automatic logic [18:0] mk(input logic ir, input logic pw, input logic [1:0] ps,
                                       input logic mr, input logic we, input logic mas,
                                       input logic rw, input logic rd, input logic [1:0] wb,
                                       input logic asb, input logic [1:0] aop,
                                       input logic h, input logic f, input logic [2:0] st);
        return {ir, pw, ps, mr, we, mas, rw, rd, wb, asb, aop, h, f, st};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Apply inputs for one cycle, check the combinational outputs, advance a clock.
    task automatic step(input string tag, input logic mr, input logic [2:0] op,
                        input logic eq, input logic [18:0] expv);
        mem_ready = mr;
        opcode    = op;
        alu_eq    = eq;
        #1;
        chk(tag, {13'd0, obs}, {13'd0, expv});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [18:0] z_rst, f_wait, f_rdy, dec, ex0, mem_lw, mem_sw, wb_alu;
        z_rst  = mk(0,0,2'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd0);
        f_wait = mk(0,0,2'd0,1,0,0,0,0,2'd0,0,2'd0,0,0,3'd0);
        f_rdy  = mk(1,0,2'd0,1,0,0,0,0,2'd0,0,2'd0,0,0,3'd0);
        dec    = mk(0,0,2'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd1);
        ex0    = mk(0,0,2'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd2);
        mem_lw = mk(0,0,2'd0,1,0,1,0,0,2'd0,0,2'd0,0,0,3'd3);
        mem_sw = mk(0,0,2'd0,1,1,1,0,0,2'd0,0,2'd0,0,0,3'd3);
        wb_alu = mk(0,1,2'd0,0,0,0,1,1,2'd1,0,2'd0,0,0,3'd4);

        reset = 1'b1; mem_ready = 1'b1; opcode = 3'd0; alu_eq = 1'b0;
        @(posedge clk); #1;
        step("rst0", 1, 3'd0, 0, z_rst);
        step("rst1", 1, 3'd0, 0, z_rst);
        reset = 1'b0;

        // add, zero-wait
        step("add_fetch", 1, 3'd0, 0, f_rdy);
        step("add_dec",   1, 3'd0, 0, dec);
        step("add_exec",  1, 3'd0, 0, mk(0,0,2'd0,0,0,0,0,0,2'd0,1,2'd0,0,0,3'd2));
        step("add_wb",    1, 3'd0, 0, wb_alu);

        // nor
        step("nor_fetch", 1, 3'd1, 0, f_rdy);
        step("nor_dec",   1, 3'd1, 0, dec);
        step("nor_exec",  1, 3'd1, 0, mk(0,0,2'd0,0,0,0,0,0,2'd0,1,2'd1,0,0,3'd2));
        step("nor_wb",    1, 3'd1, 0, wb_alu);

        // lw with 2 fetch stalls and 3 mem stalls: 10 cycles total
        step("lw_fstall0", 0, 3'd2, 0, f_wait);
        step("lw_fstall1", 0, 3'd2, 0, f_wait);
        step("lw_fetch",   1, 3'd2, 0, f_rdy);
        step("lw_dec",     1, 3'd2, 0, dec);
        step("lw_exec",    1, 3'd2, 0, ex0);
        for (int i = 0; i < 3; i++) step("lw_mstall", 0, 3'd2, 0, mem_lw);
        step("lw_mem",     1, 3'd2, 0, mem_lw);
        step("lw_wb",      1, 3'd2, 0, mk(0,1,2'd0,0,0,0,1,0,2'd0,0,2'd0,0,0,3'd4));

        // beq taken, then not taken
        step("beq1_fetch", 1, 3'd4, 1, f_rdy);
        step("beq1_dec",   1, 3'd4, 1, dec);
        step("beq1_exec",  1, 3'd4, 1, mk(0,1,2'd1,0,0,0,0,0,2'd0,1,2'd2,0,0,3'd2));
        step("beq0_fetch", 1, 3'd4, 0, f_rdy);
        step("beq0_dec",   1, 3'd4, 0, dec);
        step("beq0_exec",  1, 3'd4, 0, mk(0,1,2'd0,0,0,0,0,0,2'd0,1,2'd2,0,0,3'd2));

        // jalr
        step("jalr_fetch", 1, 3'd5, 0, f_rdy);
        step("jalr_dec",   1, 3'd5, 0, dec);
        step("jalr_exec",  1, 3'd5, 0, mk(0,1,2'd2,0,0,0,1,0,2'd2,0,2'd0,0,0,3'd2));

        // noop
        step("noop_fetch", 1, 3'd7, 0, f_rdy);
        step("noop_dec",   1, 3'd7, 0, mk(0,1,2'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd1));

        // sw: ready on the 15th stall cycle wins over the watchdog
        step("sw_fetch", 1, 3'd3, 0, f_rdy);
        step("sw_dec",   1, 3'd3, 0, dec);
        step("sw_exec",  1, 3'd3, 0, ex0);
        for (int i = 0; i < 14; i++) step("sw_mstall", 0, 3'd3, 0, mem_sw);
        step("sw_mem15", 1, 3'd3, 0, mk(0,1,2'd0,1,1,1,0,0,2'd0,0,2'd0,0,0,3'd3));

        // sw: 15 stall cycles -> FAULT, terminal, no mem_we
        step("swf_fetch", 1, 3'd3, 0, f_rdy);
        step("swf_dec",   1, 3'd3, 0, dec);
        step("swf_exec",  1, 3'd3, 0, ex0);
        for (int i = 0; i < 15; i++) step("swf_mstall", 0, 3'd3, 0, mem_sw);
        step("fault0", 1, 3'd3, 0, mk(0,0,2'd0,0,0,0,0,0,2'd0,0,2'd0,0,1,3'd6));
        step("fault1", 0, 3'd3, 0, mk(0,0,2'd0,0,0,0,0,0,2'd0,0,2'd0,0,1,3'd6));
        step("fault2", 1, 3'd0, 0, mk(0,0,2'd0,0,0,0,0,0,2'd0,0,2'd0,0,1,3'd6));

        // reset out of FAULT, then reset during a MEM stall
        reset = 1'b1;
        step("rst_fault", 1, 3'd0, 0, z_rst);
        reset = 1'b0;
        step("rm_fetch", 1, 3'd2, 0, f_rdy);
        step("rm_dec",   1, 3'd2, 0, dec);
        step("rm_exec",  1, 3'd2, 0, ex0);
        step("rm_mstall", 0, 3'd2, 0, mem_lw);
        reset = 1'b1;
        step("rst_mem", 1, 3'd2, 0, z_rst);
        reset = 1'b0;
        step("rm_after", 0, 3'd2, 0, f_wait);

        // halt, reset pulse while halted
        step("halt_fetch", 1, 3'd6, 0, f_rdy);
        step("halt_dec",   1, 3'd6, 0, dec);
        step("halt0", 1, 3'd6, 0, mk(0,0,2'd0,0,0,0,0,0,2'd0,0,2'd0,1,0,3'd5));
`ifdef LC2K_CTRL_PERF_EN
        chk("instr_count_halt", instr_count, 32'd1);
`endif
        step("halt1", 0, 3'd0, 0, mk(0,0,2'd0,0,0,0,0,0,2'd0,0,2'd0,1,0,3'd5));
        reset = 1'b1;
        step("rst_halt", 1, 3'd0, 0, z_rst);
        reset = 1'b0;
        step("post_rst", 0, 3'd0, 0, f_wait);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lc2k_mc_control.md
LC2K_MC_CONTROL -- requirements
Module: lc2k_mc_control

Interface
REQ-001 Parameter OPCODE_W, 3, opcode field width; encodings are add=0, nor=1, lw=2, sw=3, beq=4, jalr=5, halt=6, noop=7, and any other value decodes as noop.
REQ-002 Parameter MAX_WAIT, 15, maximum memory stall cycles before fault (legal range 1..255).
REQ-003 Parameter CNT_W, 32, performance counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 opcode  in  OPCODE_W  opcode from instruction register; valid in DECODE.
REQ-007 mem_ready  in  1  memory completion for the current mem_req cycle.
REQ-008 alu_eq  in  1  ALU equality result; valid in EXEC.
REQ-009 ir_write  out  1  load instruction register.
REQ-010 pc_write  out  1  update PC; pc_src  out  2  PC source: 0=pc+1, 1=branch target, 2=regA.
REQ-011 mem_req  out  1  memory request; mem_we  out  1  write when 1; mem_addr_src  out  1  address source: 0=PC, 1=ALU.
REQ-012 reg_write  out  1  register write; reg_dst  out  1  destination: 1=destReg, 0=regB; wb_src  out  2  writeback source: 0=mem, 1=ALU, 2=pc+1.
REQ-013 alu_srcB  out  1  ALU B operand: 1=regB, 0=offset; alu_op  out  2  operation: 0=add, 1=nor, 2=compare.
REQ-014 halted  out  1  in HALT; fault  out  1  in FAULT; state  out  3  current state code (debug).

Function
REQ-015 States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; state is registered, outputs are a combinational decode of state, op_q, mem_ready and alu_eq, and every output not named for a state is 0.
REQ-016 FETCH: mem_req=1, mem_addr_src=0; when mem_ready=1, ir_write=1 and next state is DECODE; otherwise remain in FETCH.
REQ-017 DECODE: latch opcode into op_q; halt goes to HALT, noop goes to FETCH with pc_write=1, pc_src=0, and all other opcodes go to EXEC.
REQ-018 EXEC add/nor: alu_srcB=1, alu_op=0/1; next state is WB.
REQ-019 EXEC lw/sw: alu_srcB=0, alu_op=0; next state is MEM.
REQ-020 EXEC beq: alu_srcB=1, alu_op=2, pc_write=1, pc_src=alu_eq?1:0; next state is FETCH.
REQ-021 EXEC jalr: reg_write=1, reg_dst=0, wb_src=2, pc_write=1, pc_src=2; next state is FETCH.
REQ-022 MEM: mem_req=1, mem_addr_src=1, mem_we=(op_q==sw); on mem_ready, lw goes to WB, and sw goes to FETCH with pc_write=1, pc_src=0.
REQ-023 WB: reg_write=1, pc_write=1, pc_src=0; add/nor use reg_dst=1, wb_src=1; lw uses reg_dst=0, wb_src=0; next state is FETCH.
REQ-024 Latency with zero-wait memory: add/nor take 4 cycles; lw takes 5; sw takes 4; beq/jalr take 3; noop takes 2.
REQ-025 wait_cnt is 8 bits; it increments each FETCH/MEM cycle with mem_ready=0 and clears on mem_ready=1 or on any state change.
REQ-026 When wait_cnt==MAX_WAIT-1 and mem_ready=0, the next state is FAULT; if mem_ready=1 in that same cycle, ready wins.
REQ-027 HALT and FAULT are terminal until reset; halted=1 in HALT, fault=1 in FAULT, and all other outputs are 0.

Reset
REQ-028 While reset=1, every output other than state is forced to 0 and state reads FETCH.
REQ-029 Reset sets state=FETCH, op_q=noop, wait_cnt=0 and counters to 0; the first request is issued the cycle after reset deasserts.
REQ-030 Reset asserted mid-operation, including during a MEM stall, aborts the access with no pc_write or reg_write issued in that cycle.

Configuration
REQ-031 Macro LC2K_CTRL_PERF_EN: when defined, output ports cycle_count (CNT_W) and instr_count (CNT_W) exist.
REQ-032 With LC2K_CTRL_PERF_EN defined: cycle_count increments every cycle outside HALT/FAULT; instr_count increments on each pc_write=1 cycle and on entry to HALT; both saturate at all-ones.
REQ-033 Without LC2K_CTRL_PERF_EN: cycle_count and instr_count ports and logic are absent, and all other behaviour is identical.

Verification
REQ-034 add, mem_ready tied 1 -> states 0,1,2,4; in WB cycle 4, reg_write=1, reg_dst=1, wb_src=1, pc_write=1.
REQ-035 lw, mem_ready low 2 cycles in FETCH and 3 cycles in MEM -> 10 cycles total; WB shows reg_dst=0, wb_src=0.
REQ-036 beq with alu_eq=1, then beq with alu_eq=0 -> EXEC pc_src=1, then pc_src=0; reg_write=0 throughout.
REQ-037 MAX_WAIT=15, mem_ready held 0 in MEM for sw -> fault=1 after 15 stall cycles, mem_we never asserted after FAULT; mem_ready=1 on the 15th stall cycle -> no fault.
REQ-038 halt, then reset pulse while in HALT -> halted=1 until reset; after reset, state=0 and mem_req=1 on the next cycle; with LC2K_CTRL_PERF_EN, instr_count=1 at halt.
